pc_predict: RTL and testbench

Parametrised PC-selection and prediction stage for the pipelined Y86-64 core, replacing the single-cycle PC update unit. Each cycle it selects the fetch PC from the predicted PC, a mispredicted-branch correction from M, or a return-address correction from W. It also holds the F pipeline register (predicted PC). An optional return-address stack (RAS) predicts `ret` targets instead of stalling.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/ras_stack.sv | 52 +++++
 rtl/pc_predict.sv | 96 +++++++++
 tb/tb_pc_predict.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the default address width.
package y86_pkg;

  localparam int ADDR_W_DEFAULT = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Short aliases used by the PC prediction logic
  localparam logic [3:0] JXX  = IJXX;
  localparam logic [3:0] CALL = ICALL;
  localparam logic [3:0] RET  = IRET;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a saturating valid count.
// When full, a push wraps and overwrites the oldest entry; a pop on an
// empty stack leaves pointer and count untouched. Clear wins over push/pop.
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  // ptr names the next free slot, so the most recent entry sits just below it
  assign top = mem[ptr - PTR_W'(1)];

  // Pointer and valid-count bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != FULL)
        count <= count + CNT_W'(1);
    end else if (pop && (count != '0)) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents need no reset because count gates their use
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_predict.sv
// PC selection and prediction stage: picks the fetch PC from the prediction
// or a late correction from M/W, and holds the F register. An optional
// return-address stack predicts ret targets.
module pc_predict
  import y86_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEFAULT,
  parameter int          RAS_DEPTH = 8,
  parameter int          RAS_EN    = 1,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        f_stall,
  input  logic [3:0]                  f_icode,
  input  logic [ADDR_W-1:0]           f_valC,
  input  logic [ADDR_W-1:0]           f_valP,
  input  logic [3:0]                  M_icode,
  input  logic                        M_cnd,
  input  logic [ADDR_W-1:0]           M_valA,
  input  logic [3:0]                  W_icode,
  input  logic [ADDR_W-1:0]           W_valM,
  input  logic [ADDR_W-1:0]           W_predPC,
  output logic [ADDR_W-1:0]           f_pc,
  output logic [ADDR_W-1:0]           F_predPC,
  output logic                        jxx_mispredict,
  output logic                        ret_mispredict,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  localparam bit HAS_RAS = (RAS_EN != 0);

  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] pred_pc;

  // Without a RAS every ret is a guaranteed mispredict resolved in W
  assign ret_mispredict = (W_icode == RET) && (HAS_RAS ? (W_valM != W_predPC) : 1'b1);
  assign jxx_mispredict = (M_icode == JXX) && !M_cnd;

  generate
    if (HAS_RAS) begin : g_ras
      logic ras_push;
      logic ras_pop;
      logic ras_clear;

      assign ras_clear = ret_mispredict && !f_stall;
      assign ras_push  = !f_stall && !ret_mispredict && (f_icode == CALL);
      assign ras_pop   = !f_stall && !ret_mispredict && (f_icode == RET);

      ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
      ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (f_valP),
        .top       (ras_top),
        .count     (ras_count)
      );
    end else begin : g_no_ras
      assign ras_top   = '0;
      assign ras_count = '0;
    end
  endgenerate

  // Fetch PC select: the older W correction beats the M correction
  always_comb begin
    f_pc = F_predPC;
    if (ret_mispredict)
      f_pc = W_valM;
    else if (jxx_mispredict)
      f_pc = M_valA;
  end

  // Successor prediction for the instruction fetched this cycle
  always_comb begin
    pred_pc = f_valP;
    case (f_icode)
      JXX, CALL: pred_pc = f_valC;
      RET:       if (HAS_RAS && (ras_count != '0)) pred_pc = ras_top;
      default:   pred_pc = f_valP;
    endcase
  end

  // F pipeline register, held while fetch is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      F_predPC <= RESET_PC[ADDR_W-1:0];
    else if (!f_stall)
      F_predPC <= pred_pc;
  end

endmodule

// File: tb/tb_pc_predict.sv
// Self-checking bench for pc_predict: one RAS-enabled instance (depth 4,
// reset PC 32) and one RAS-less instance share the same stimulus.
module tb_pc_predict;

  localparam logic [3:0] NOP  = 4'h1;
  localparam logic [3:0] JXX  = 4'h7;
  localparam logic [3:0] CALL = 4'h8;
  localparam logic [3:0] RET  = 4'h9;
  localparam int         DEPTH_A = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_stall;
  logic [3:0]  f_icode, m_icode, w_icode;
  logic        m_cnd;
  logic [63:0] f_valc, f_valp, m_vala, w_valm, w_predpc;

  logic [63:0] f_pc_a, pred_pc_a, f_pc_b, pred_pc_b;
  logic        jxx_a, ret_a, jxx_b, ret_b;
  logic [2:0]  ras_count_a;
  logic [3:0]  ras_count_b;

  // Reference state: predicted PCs and the return addresses as a plain list
  logic [63:0] model_pred_a, model_pred_b;
  logic [63:0] ras_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  pc_predict #(.ADDR_W(64), .RAS_DEPTH(DEPTH_A), .RAS_EN(1), .RESET_PC(64'd32)) dut_a (
    .clk(clk), .reset(reset), .f_stall(f_stall), .f_icode(f_icode),
    .f_valC(f_valc), .f_valP(f_valp), .M_icode(m_icode), .M_cnd(m_cnd),
    .M_valA(m_vala), .W_icode(w_icode), .W_valM(w_valm), .W_predPC(w_predpc),
    .f_pc(f_pc_a), .F_predPC(pred_pc_a), .jxx_mispredict(jxx_a),
    .ret_mispredict(ret_a), .ras_count(ras_count_a)
  );

  pc_predict #(.ADDR_W(64), .RAS_DEPTH(8), .RAS_EN(0), .RESET_PC(64'd0)) dut_b (
    .clk(clk), .reset(reset), .f_stall(f_stall), .f_icode(f_icode),
    .f_valC(f_valc), .f_valP(f_valp), .M_icode(m_icode), .M_cnd(m_cnd),
    .M_valA(m_vala), .W_icode(w_icode), .W_valM(w_valm), .W_predPC(w_predpc),
    .f_pc(f_pc_b), .F_predPC(pred_pc_b), .jxx_mispredict(jxx_b),
    .ret_mispredict(ret_b), .ras_count(ras_count_b)
  );

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] fi, input logic [63:0] vc, input logic [63:0] vp,
                               input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                               input logic [3:0] wi, input logic [63:0] wm, input logic [63:0] wp,
                               input logic st);
    f_icode = fi; f_valc = vc; f_valp = vp;
    m_icode = mi; m_cnd = mc; m_vala = ma;
    w_icode = wi; w_valm = wm; w_predpc = wp;
    f_stall = st;
    #1;
  endtask

  // Checks the redirect outputs now, then clocks once and checks the registers
  task automatic checkOutput(input string tag);
    logic        jxx_exp, ret_exp_a, ret_exp_b;
    logic [63:0] fpc_exp_a, fpc_exp_b;
    jxx_exp   = (m_icode == JXX) && !m_cnd;
    ret_exp_a = (w_icode == RET) && (w_valm != w_predpc);
    ret_exp_b = (w_icode == RET);
    fpc_exp_a = ret_exp_a ? w_valm : (jxx_exp ? m_vala : model_pred_a);
    fpc_exp_b = ret_exp_b ? w_valm : (jxx_exp ? m_vala : model_pred_b);
    compare({tag, "/f_pc_a"}, f_pc_a, fpc_exp_a);
    compare({tag, "/jxx_a"}, 64'(jxx_a), 64'(jxx_exp));
    compare({tag, "/ret_a"}, 64'(ret_a), 64'(ret_exp_a));
    compare({tag, "/f_pc_b"}, f_pc_b, fpc_exp_b);
    compare({tag, "/jxx_b"}, 64'(jxx_b), 64'(jxx_exp));
    compare({tag, "/ret_b"}, 64'(ret_b), 64'(ret_exp_b));
    if (!f_stall) begin
      case (f_icode)
        JXX, CALL: begin model_pred_a = f_valc; model_pred_b = f_valc; end
        RET: begin
          model_pred_a = (ras_q.size() > 0) ? ras_q[$] : f_valp;
          model_pred_b = f_valp;
        end
        default: begin model_pred_a = f_valp; model_pred_b = f_valp; end
      endcase
      if (ret_exp_a) ras_q.delete();
      else if (f_icode == CALL) begin
        ras_q.push_back(f_valp);
        if (ras_q.size() > DEPTH_A) void'(ras_q.pop_front());
      end else if ((f_icode == RET) && (ras_q.size() > 0)) void'(ras_q.pop_back());
    end
    @(posedge clk);
    #1;
    compare({tag, "/pred_a"}, pred_pc_a, model_pred_a);
    compare({tag, "/count_a"}, 64'(ras_count_a), 64'(ras_q.size()));
    compare({tag, "/pred_b"}, pred_pc_b, model_pred_b);
    compare({tag, "/count_b"}, 64'(ras_count_b), 64'd0);
  endtask

  initial begin
    logic [63:0] ret_expect [5];
    logic [63:0] wv, ma;
    logic [3:0]  fi, mi, wi;
    int          r;
    ret_expect[0] = 64'd6; ret_expect[1] = 64'd5; ret_expect[2] = 64'd4;
    ret_expect[3] = 64'd3; ret_expect[4] = 64'h305;

    // Reset state with no M/W events
    reset = 1'b1;
    f_icode = NOP; f_valc = '0; f_valp = '0; m_icode = NOP; m_cnd = 1'b0; m_vala = '0;
    w_icode = NOP; w_valm = '0; w_predpc = '0; f_stall = 1'b0;
    model_pred_a = 64'd32; model_pred_b = 64'd0;
    #12;
    compare("reset/pred_a", pred_pc_a, 64'd32);
    compare("reset/f_pc_a", f_pc_a, 64'd32);
    compare("reset/count_a", 64'(ras_count_a), 64'd0);
    compare("reset/pred_b", pred_pc_b, 64'd0);
    reset = 1'b0;

    // Branch predicted taken, then resolved not-taken in M
    applyStimulus(JXX, 64'h100, 64'h34, NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
    checkOutput("jxx_fetch");
    compare("jxx_fetch/taken", pred_pc_a, 64'h100);
    applyStimulus(NOP, 64'h0, 64'h2C, JXX, 1'b0, 64'h2A, NOP, 64'h0, 64'h0, 1'b0);
    checkOutput("jxx_mis");
    compare("jxx_mis/f_pc", f_pc_a, 64'h2A);

    // Call then ret, with a correctly predicted ret reaching W
    applyStimulus(CALL, 64'h80, 64'h29, NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
    checkOutput("call");
    compare("call/count", 64'(ras_count_a), 64'd1);
    applyStimulus(RET, 64'h0, 64'h81, NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
    checkOutput("ret");
    compare("ret/pred", pred_pc_a, 64'h29);
    compare("ret/count", 64'(ras_count_a), 64'd0);
    applyStimulus(NOP, 64'h0, 64'h2A, NOP, 1'b0, 64'h0, RET, 64'h29, 64'h29, 1'b0);
    checkOutput("ret_ok");

    // Ret mispredict in W together with a jXX mispredict in M
    applyStimulus(CALL, 64'h80, 64'h29, NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
    checkOutput("call2");
    applyStimulus(CALL, 64'h90, 64'h55, JXX, 1'b0, 64'h2A, RET, 64'h50, 64'h29, 1'b0);
    checkOutput("both_mis");
    compare("both_mis/f_pc", f_pc_a, 64'h50);
    compare("both_mis/count", 64'(ras_count_a), 64'd0);

    // Overfill a depth-4 stack, then drain it past empty
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(CALL, 64'h200 + 64'(i), 64'(i), NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
      checkOutput("ras_fill");
    end
    compare("ras_fill/sat", 64'(ras_count_a), 64'd4);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(RET, 64'h0, 64'h300 + 64'(i), NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
      checkOutput("ras_drain");
      compare("ras_drain/pred", pred_pc_a, ret_expect[i-1]);
    end
    compare("ras_drain/empty", 64'(ras_count_a), 64'd0);

    // Stalled call changes nothing
    applyStimulus(CALL, 64'h400, 64'h44, NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
    checkOutput("pre_stall");
    applyStimulus(CALL, 64'h500, 64'h66, NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b1);
    checkOutput("stall");
    compare("stall/pred", pred_pc_a, 64'h400);
    compare("stall/count", 64'(ras_count_a), 64'd1);

    // Reset asserted mid-cycle discards the stack at once
    applyStimulus(CALL, 64'h600, 64'h77, NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
    checkOutput("pre_reset");
    applyStimulus(NOP, 64'h0, 64'h0, NOP, 1'b0, 64'h0, NOP, 64'h0, 64'h0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    model_pred_a = 64'd32; model_pred_b = 64'd0; ras_q.delete();
    compare("mid_reset/pred_a", pred_pc_a, 64'd32);
    compare("mid_reset/count_a", 64'(ras_count_a), 64'd0);
    compare("mid_reset/f_pc_a", f_pc_a, 64'd32);
    compare("mid_reset/pred_b", pred_pc_b, 64'd0);
    #3;
    reset = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) fi = CALL;
      else if (r < 6) fi = RET;
      else if (r == 6) fi = JXX;
      else fi = 4'($urandom_range(0, 11));
      mi = ($urandom_range(0, 3) == 0) ? JXX : 4'($urandom_range(0, 6));
      wi = ($urandom_range(0, 4) == 0) ? RET : NOP;
      wv = {32'h0, $urandom};
      ma = {$urandom, $urandom};
      applyStimulus(fi, {$urandom, $urandom}, {32'h0, $urandom}, mi, 1'($urandom_range(0, 1)), ma,
                    wi, wv, ($urandom_range(0, 1) == 0) ? wv : {32'h0, $urandom},
                    ($urandom_range(0, 9) == 0));
      checkOutput("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
